// File: rtl/timer_ctrl_pkg.sv
// timer_ctrl_pkg: shared FSM state type and default widths for timer_ctrl
package timer_ctrl_pkg;
  typedef enum logic {IDLE, RUN} timer_state_t;
  localparam int TIMER_WIDTH = 24;
  localparam int TIMER_PRE_WIDTH = 16;
endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: PRE_WIDTH up-counter with sync clear, enable and latched terminal value
//   clk, reset (async active-low) | load: latch term and restart at 0 | clr: sync clear
//   en: count while running | term: terminal value to latch | wrap: registered strobe, high
//   during the cycle in which the counter sits at the latched terminal value
module timer_prescaler import timer_ctrl_pkg::*; #(
  parameter int PRE_WIDTH = TIMER_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 clr,
  input  logic                 en,
  input  logic [PRE_WIDTH-1:0] term,
  output logic                 wrap
);
  logic [PRE_WIDTH-1:0] cnt_q, cnt_d, term_q, term_d;
  always_comb begin
    term_d = load ? term : term_q;
    cnt_d  = (clr || load) ? '0 : en ? (wrap ? '0 : cnt_q + 1'b1) : cnt_q;
  end
  // wrap is computed from the next counter value so it is a flop output yet
  // aligned with the cycle in which the counter equals the terminal value
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      cnt_q  <= '0;
      term_q <= '0;
      wrap   <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      term_q <= term_d;
      wrap   <= !clr && (en || load) && cnt_d == term_d;
    end
endmodule

// File: rtl/timer_ctrl.sv
// timer_ctrl: programmable interval timer with prescaled tick, one-shot or periodic expiry
//   clk, reset (async active-low) | start/ready handshake latches interval, prescale, periodic
//   stop: abort a running timer | busy: running | tick: one pulse per prescaled period
//   done: pulse at expiry | count: remaining ticks
//   TIMER_CTRL_PERIODIC_EN: when defined, periodic auto-reload is built; otherwise every run is one-shot
module timer_ctrl import timer_ctrl_pkg::*; #(
  parameter int WIDTH     = TIMER_WIDTH,
  parameter int PRE_WIDTH = TIMER_PRE_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     interval,
  input  logic [PRE_WIDTH-1:0] prescale,
  input  logic                 periodic,
  input  logic                 stop,
  output logic                 ready,
  output logic                 busy,
  output logic                 tick,
  output logic                 done,
  output logic [WIDTH-1:0]     count
);
  timer_state_t state_q, state_d;
  logic [WIDTH-1:0] interval_q, interval_d, count_d;
  logic tick_d, done_d, wrap, load, clr, last, reload;
  assign ready = state_q == IDLE;
  assign busy  = state_q == RUN;
  assign load  = ready && start && interval != '0;
  assign last  = busy && !stop && wrap && count == WIDTH'(1);
  assign clr   = busy && (stop || (last && !reload));
`ifdef TIMER_CTRL_PERIODIC_EN
  logic periodic_q;
  always_ff @(posedge clk or negedge reset)
    if (!reset) periodic_q <= 1'b0;
    else if (load) periodic_q <= periodic;
  assign reload = periodic_q;
`else
  logic unused_periodic;
  assign unused_periodic = periodic;
  assign reload = 1'b0;
`endif
  timer_prescaler #(.PRE_WIDTH(PRE_WIDTH)) u_pre (
    .clk  (clk),
    .reset(reset),
    .load (load),
    .clr  (clr),
    .en   (busy),
    .term (prescale),
    .wrap (wrap)
  );
  always_comb begin
    state_d    = state_q;
    count_d    = count;
    interval_d = interval_q;
    tick_d     = 1'b0;
    done_d     = 1'b0;
    if (ready) begin
      if (load) begin
        state_d    = RUN;
        count_d    = interval;
        interval_d = interval;
      end else done_d = start;
    end else if (stop) begin
      state_d = IDLE;
      count_d = '0;
    end else if (wrap) begin
      tick_d  = 1'b1;
      done_d  = last;
      state_d = (last && !reload) ? IDLE : RUN;
      count_d = last ? (reload ? interval_q : '0) : count - 1'b1;
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state_q    <= IDLE;
      interval_q <= '0;
      count      <= '0;
      tick       <= 1'b0;
      done       <= 1'b0;
    end else begin
      state_q    <= state_d;
      interval_q <= interval_d;
      count      <= count_d;
      tick       <= tick_d;
      done       <= done_d;
    end
endmodule

// File: tb/tb_timer_ctrl.sv
// tb_timer_ctrl: scoreboard bench for timer_ctrl against a closed-form schedule model
module tb_timer_ctrl;
`ifdef TIMER_CTRL_PERIODIC_EN
  localparam bit PER_EN = 1'b1;
`else
  localparam bit PER_EN = 1'b0;
`endif
  localparam logic [27:0] IDLE_E = {4'b1000, 24'd0};
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, periodic = 1'b0, stop = 1'b0;
  logic [23:0] interval = '0;
  logic [15:0] prescale = '0;
  logic ready, busy, tick, done;
  logic [23:0] count;
  logic [27:0] q[$];
  logic chk_en = 1'b0;
  int checks = 0, failures = 0, tick_seen = 0, done_seen = 0, cyc = 0;
  bit run = 1'b0, mper = 1'b0;
  int rs = 0, mn = 0, mp = 0;

  timer_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .interval(interval), .prescale(prescale),
    .periodic(periodic), .stop(stop), .ready(ready), .busy(busy), .tick(tick),
    .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Outputs of a run in absolute cycle x, from the schedule rule:
  // ticks at rs + k(P+1), done on every N-th tick, count = ticks still to go.
  function automatic logic [27:0] run_exp(int x);
    int s, k;
    logic t;
    s = x - rs;
    k = s / (mp + 1);
    t = s > 0 && s % (mp + 1) == 0;
    if (mper) return {1'b0, 1'b1, t, t && k % mn == 0, 24'(mn - k % mn)};
    if (k >= mn) return {4'b1011, 24'd0};
    return {1'b0, 1'b1, t, 1'b0, 24'(mn - k)};
  endfunction

  always @(negedge clk) if (chk_en) begin
    logic [27:0] e;
    checks++;
    if (q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty cyc=%0d", cyc);
    end else begin
      e = q.pop_front();
      if ({ready, busy, tick, done, count} !== e) begin
        failures++;
        $display("FAIL outputs cyc=%0d got rbtd=%b count=%0d, expected rbtd=%b count=%0d",
                 cyc, {ready, busy, tick, done}, count, e[27:24], e[23:0]);
      end
    end
    tick_seen += int'(tick);
    done_seen += int'(done);
  end

  task automatic step(input logic st, input logic [23:0] iv, input logic [15:0] ps,
                      input logic pe, input logic sp);
    logic [27:0] e;
    @(posedge clk);
    #1;
    start = st; interval = iv; prescale = ps; periodic = pe; stop = sp;
    cyc++;
    if (!run) begin
      if (st && iv == 0) e = {4'b1001, 24'd0};
      else if (st) begin
        run = 1'b1; rs = cyc + 1; mn = int'(iv); mp = int'(ps); mper = PER_EN & pe;
        e = run_exp(cyc + 1);
      end else e = IDLE_E;
    end else if (sp) begin
      run = 1'b0;
      e = IDLE_E;
    end else begin
      e = run_exp(cyc + 1);
      if (!mper && e[24]) run = 1'b0;
    end
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3;
    chk_en = 1'b0;
    q.delete();
    start = 1'b0; stop = 1'b0;
    reset = 1'b0;
    #1;
    checks++;
    if ({ready, busy, tick, done, count} !== IDLE_E) begin
      failures++;
      $display("FAIL async_reset got rbtd=%b count=%0d, expected rbtd=1000 count=0",
               {ready, busy, tick, done}, count);
    end
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    run = 1'b0;
    q.push_back(IDLE_E);
    q.push_back(IDLE_E);
    chk_en = 1'b1;
  endtask

  task automatic tally(input string name, input int t0, input int d0, input int et, input int ed);
    checks++;
    if (tick_seen - t0 != et || done_seen - d0 != ed) begin
      failures++;
      $display("FAIL %s ticks=%0d dones=%0d, expected ticks=%0d dones=%0d",
               name, tick_seen - t0, done_seen - d0, et, ed);
    end
  endtask

  initial begin
    int t0, d0;
    do_reset();
    idle(2);
    // one-shot N=3 P=2: ticks in cycles 4, 7, 10, done with ready in 10
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd3, 16'd2, 1'b0, 1'b0);
    idle(15);
    tally("oneshot_3_2", t0, d0, 3, 1);
    // interval 0: immediate done, no tick
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd0, 16'd5, 1'b1, 1'b0);
    idle(4);
    tally("interval_zero", t0, d0, 0, 1);
    // periodic N=2 P=0, stop sampled in cycle 6
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd2, 16'd0, 1'b1, 1'b0);
    idle(5);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(6);
    tally("periodic_stop", t0, d0, PER_EN ? 5 : 2, PER_EN ? 2 : 1);
    // stop on the final wrap suppresses tick and done
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd1, 16'd4, 1'b0, 1'b0);
    idle(4);
    step(1'b0, '0, '0, 1'b0, 1'b1);
    idle(8);
    tally("stop_final_wrap", t0, d0, 0, 0);
    // start while running is ignored
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd3, 16'd1, 1'b0, 1'b0);
    step(1'b1, 24'd7, 16'd0, 1'b0, 1'b0);
    idle(10);
    tally("start_in_run", t0, d0, 3, 1);
    // start together with stop in IDLE is accepted
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd2, 16'd0, 1'b0, 1'b1);
    idle(6);
    tally("start_stop_idle", t0, d0, 2, 1);
    // async reset in the middle of a run, then the first scenario again
    step(1'b1, 24'd5, 16'd3, 1'b0, 1'b0);
    idle(6);
    do_reset();
    t0 = tick_seen; d0 = done_seen;
    step(1'b1, 24'd3, 16'd2, 1'b0, 1'b0);
    idle(15);
    tally("after_reset", t0, d0, 3, 1);
    // randomized traffic against the schedule model
    for (int i = 0; i < 4000; i++) begin
      logic [23:0] iv;
      int r;
      r = $urandom_range(0, 9);
      iv = r == 0 ? 24'd0 : r == 1 ? 24'd1 : r == 9 ? 24'($urandom) : 24'($urandom_range(2, 6));
      if (i % 900 == 899) do_reset();
      else step($urandom_range(0, 3) == 0, iv, 16'($urandom_range(0, 4)),
                1'($urandom_range(0, 1)), $urandom_range(0, 29) == 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
